storage_sequencer: RTL
======================

STORAGE_SEQUENCER -- requirements
Module: storage_sequencer

Interface
REQ-001 SHALL have parameters: SSIDBITS, 10, SSID width; NCOLS_HIM, 8, hit-info width; MAX_HITS, 256, writes accepted per event (1..65535).
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 startEvent  in  1  begin event (honoured in IDLE only).
REQ-005 endEvent  in  1  stop writing, start readout (honoured in WRITE only).
REQ-006 req0Valid/req1Valid  in  1  requester has a hit.
REQ-007 req0SSID/req1SSID  in  SSIDBITS; req0HitInfo/req1HitInfo  in  NCOLS_HIM  requester data.
REQ-008 req0Grant/req1Grant  out  1  combinational; hit accepted at this edge.
REQ-009 storageReady, readReady  in  1  status from storage.
REQ-010 clearMemory, readMemory, newAddress  out  1  registered single-cycle strobes to storage.
REQ-011 SSID  out  SSIDBITS; hitInfo  out  NCOLS_HIM  registered write data.
REQ-012 busy  out  1  state != IDLE; hitCount  out  16  writes this event; overflow  out  1  sticky.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, WRITE, READ.
REQ-014 IDLE: startEvent=1 -> CLEAR; clearMemory=1 the next cycle only; hitCount<=0, overflow<=0.
REQ-015 CLEAR: SHALL stay until storageReady=1 with clearMemory low, then -> WRITE.
REQ-016 WRITE: grant eligible when storageReady=1, newAddress=0, endEvent=0, hitCount<MAX_HITS.
REQ-017 At most one grant per cycle; grant only to a requester with Valid=1.
REQ-018 Requester SHALL hold Valid and data stable until its grant; Valid without grant is not consumed.
REQ-019 Cycle after grant: newAddress=1 for one cycle, SSID/hitInfo = granted data, hitCount+1.
REQ-020 SSID/hitInfo SHALL hold last value when newAddress=0.
REQ-021 Arbitration (default): round-robin; last-granted loses a tie; pointer resets to favour req0.
REQ-022 Eligible but hitCount==MAX_HITS and any Valid=1: overflow<=1; no grant; hitCount saturates.
REQ-023 endEvent=1 in WRITE: no grant that cycle; -> READ; readMemory=1 the cycle after newAddress is 0.
REQ-024 READ: wait readReady=1, then -> IDLE; busy falls same edge.
REQ-025 startEvent outside IDLE and endEvent outside WRITE SHALL be ignored.
REQ-026 startEvent and endEvent both high in IDLE: startEvent only.
REQ-027 Grants SHALL be 0 in IDLE, CLEAR, READ.

Reset
REQ-028 reset=1 SHALL force IDLE immediately, any state.
REQ-029 Reset values: clearMemory, readMemory, newAddress, grants, busy, overflow = 0; hitCount, SSID, hitInfo = 0; pointer = req0.
REQ-030 Reset mid-WRITE SHALL drop pending write; no newAddress after reset release.

Configuration
REQ-031 Macro SEQ_FIXED_PRIORITY_EN defined: req0 always wins over req1; pointer absent.
REQ-032 Undefined: round-robin per REQ-021.

Verification
REQ-033 reset, startEvent 1 cycle, storageReady=1 -> clearMemory 1 cycle, WRITE 2 cycles after startEvent.
REQ-034 WRITE, both Valid held 4 grants -> order req0,req1,req0,req1 (fixed-priority build: req0 x4); hitCount=4.
REQ-035 MAX_HITS=3, req0Valid held -> 3 newAddress pulses, overflow=1, hitCount=3, no 4th grant.
REQ-036 endEvent with req1Valid=1 same cycle -> no grant, readMemory 1 cycle, readReady=1 -> IDLE, busy=0.
REQ-037 reset asserted 1 cycle after grant -> newAddress=0, busy=0, hitCount=0 asynchronously.
REQ-038 storageReady=0 in WRITE with Valid=1 -> no grant until storageReady=1, then grant next edge.

Source files
------------

// File: rtl/storage_sequencer.sv
// Storage sequencer: clears storage, arbitrates two hit requesters into sequential writes, then
// triggers readout. Define SEQ_FIXED_PRIORITY_EN for fixed req0-over-req1 priority (default: round-robin).
module storage_sequencer #(
  parameter int unsigned SSIDBITS  = 10,
  parameter int unsigned NCOLS_HIM = 8,
  parameter int unsigned MAX_HITS  = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 startEvent,
  input  logic                 endEvent,
  input  logic                 req0Valid,
  input  logic [SSIDBITS-1:0]  req0SSID,
  input  logic [NCOLS_HIM-1:0] req0HitInfo,
  input  logic                 req1Valid,
  input  logic [SSIDBITS-1:0]  req1SSID,
  input  logic [NCOLS_HIM-1:0] req1HitInfo,
  output logic                 req0Grant,
  output logic                 req1Grant,
  input  logic                 storageReady,
  input  logic                 readReady,
  output logic                 clearMemory,
  output logic                 readMemory,
  output logic                 newAddress,
  output logic [SSIDBITS-1:0]  SSID,
  output logic [NCOLS_HIM-1:0] hitInfo,
  output logic                 busy,
  output logic [15:0]          hitCount,
  output logic                 overflow
);

  localparam logic [15:0] MaxHits = 16'(MAX_HITS);

  typedef enum logic [1:0] {StIdle, StClear, StWrite, StRead} state_e;

  state_e               state_q, state_d;
  logic                 clear_q, clear_d;
  logic                 read_q, read_d;
  logic                 new_addr_q, new_addr_d;
  logic                 read_sent_q, read_sent_d;
  logic [SSIDBITS-1:0]  ssid_q, ssid_d;
  logic [NCOLS_HIM-1:0] hit_info_q, hit_info_d;
  logic [15:0]          hit_count_q, hit_count_d;
  logic                 overflow_q, overflow_d;

  logic can_write;
  logic below_max;
  logic any_valid;
  logic pick0;
  logic pick1;
  logic grant0;
  logic grant1;

  // A write slot is open only while the previous write strobe is low.
  always_comb begin
    can_write = (state_q == StWrite) && storageReady && !new_addr_q && !endEvent;
    below_max = hit_count_q < MaxHits;
    any_valid = req0Valid || req1Valid;
  end

`ifdef SEQ_FIXED_PRIORITY_EN
  always_comb begin
    pick0 = req0Valid;
    pick1 = req1Valid && !req0Valid;
  end
`else
  // last0_q set means req0 won the most recent grant, so req1 wins the next tie.
  logic last0_q, last0_d;

  always_comb begin
    pick0   = req0Valid && (!req1Valid || !last0_q);
    pick1   = req1Valid && (!req0Valid || last0_q);
    last0_d = (grant0 || grant1) ? grant0 : last0_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last0_q <= 1'b0;
    end else begin
      last0_q <= last0_d;
    end
  end
`endif

  always_comb begin
    grant0 = can_write && below_max && pick0;
    grant1 = can_write && below_max && pick1;
  end

  always_comb begin
    state_d     = state_q;
    clear_d     = 1'b0;
    read_d      = 1'b0;
    new_addr_d  = 1'b0;
    read_sent_d = read_sent_q;
    ssid_d      = ssid_q;
    hit_info_d  = hit_info_q;
    hit_count_d = hit_count_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (startEvent) begin
          state_d     = StClear;
          clear_d     = 1'b1;
          hit_count_d = '0;
          overflow_d  = 1'b0;
        end
      end
      StClear: begin
        if (storageReady && !clear_q) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (endEvent) begin
          // Readout waits until any in-flight write strobe has been issued.
          state_d     = StRead;
          read_d      = !new_addr_q;
          read_sent_d = !new_addr_q;
        end else if (grant0 || grant1) begin
          new_addr_d  = 1'b1;
          hit_count_d = hit_count_q + 16'd1;
          ssid_d      = grant0 ? req0SSID : req1SSID;
          hit_info_d  = grant0 ? req0HitInfo : req1HitInfo;
        end else if (can_write && !below_max && any_valid) begin
          overflow_d = 1'b1;
        end
      end
      StRead: begin
        if (!read_sent_q) begin
          if (!new_addr_q) begin
            read_d      = 1'b1;
            read_sent_d = 1'b1;
          end
        end else if (readReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      clear_q     <= 1'b0;
      read_q      <= 1'b0;
      new_addr_q  <= 1'b0;
      read_sent_q <= 1'b0;
      ssid_q      <= '0;
      hit_info_q  <= '0;
      hit_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_q     <= clear_d;
      read_q      <= read_d;
      new_addr_q  <= new_addr_d;
      read_sent_q <= read_sent_d;
      ssid_q      <= ssid_d;
      hit_info_q  <= hit_info_d;
      hit_count_q <= hit_count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    req0Grant   = grant0;
    req1Grant   = grant1;
    clearMemory = clear_q;
    readMemory  = read_q;
    newAddress  = new_addr_q;
    SSID        = ssid_q;
    hitInfo     = hit_info_q;
    busy        = state_q != StIdle;
    hitCount    = hit_count_q;
    overflow    = overflow_q;
  end

endmodule
